// File: rtl/alu_pkg.sv
// Shared operation codes, FSM states and width default for the ALU decoder and alu_exec.
// Optional feature macro used by this slice: ALU_BARREL_SHIFT_EN.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd14;
    localparam logic [3:0] ALU_SLTU = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle combinational ALU operations; with ALU_BARREL_SHIFT_EN it also
// performs full shifts, otherwise shift codes pass op_a through (shift by zero).
module alu_comb
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      alu_ctr,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (alu_ctr)
            ALU_ADD:  result = op_a + op_b;
            ALU_SUB:  result = op_a - op_b;
            ALU_AND:  result = op_a & op_b;
            ALU_OR:   result = op_a | op_b;
            ALU_XOR:  result = op_a ^ op_b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL:  result = op_a << op_b[4:0];
            ALU_SRL:  result = op_a >> op_b[4:0];
            ALU_SRA:  result = XLEN'($signed(op_a) >>> op_b[4:0]);
`else
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  result = op_a;
`endif
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Registered execute unit with valid/ready handshake and a serial one-bit-per-cycle
// shifter; defining ALU_BARREL_SHIFT_EN replaces the serial shifter with a barrel shift.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctr,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    state_t          state;
    logic [XLEN-1:0] comb_result;
    logic            in_fire;

    alu_comb #(.XLEN(XLEN)) u_comb (
        .alu_ctr (alu_ctr),
        .op_a    (op_a),
        .op_b    (op_b),
        .result  (comb_result)
    );

    // HOLD with out_ready lets the draining result and a new capture share one edge.
    assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state == ST_HOLD);

`ifdef ALU_BARREL_SHIFT_EN

    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            result <= '0;
            zero   <= 1'b1;
        end else if (in_fire) begin
            result <= comb_result;
            zero   <= (comb_result == '0);
            state  <= ST_HOLD;
        end else if ((state == ST_HOLD) && out_ready) begin
            state  <= ST_IDLE;
        end
    end

`else

    logic [XLEN-1:0] work;
    logic [XLEN-1:0] work_next;
    logic [4:0]      count;
    logic [3:0]      code;
    logic            start_shift;

    assign start_shift = is_shift(alu_ctr) && (op_b[4:0] != 5'd0);
    assign busy        = (state == ST_SHIFT);

    always_comb begin
        work_next = {1'b0, work[XLEN-1:1]};
        case (code)
            ALU_SLL: work_next = {work[XLEN-2:0], 1'b0};
            ALU_SRA: work_next = {work[XLEN-1], work[XLEN-1:1]};
            default: work_next = {1'b0, work[XLEN-1:1]};
        endcase
    end

    // The last shift step writes straight into result so out_valid rises at N+1+s.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            result <= '0;
            zero   <= 1'b1;
            work   <= '0;
            count  <= '0;
            code   <= ALU_ADD;
        end else if (in_fire) begin
            if (start_shift) begin
                work  <= op_a;
                count <= op_b[4:0];
                code  <= alu_ctr;
                state <= ST_SHIFT;
            end else begin
                result <= comb_result;
                zero   <= (comb_result == '0);
                state  <= ST_HOLD;
            end
        end else if (state == ST_SHIFT) begin
            work  <= work_next;
            count <= count - 5'd1;
            if (count == 5'd1) begin
                result <= work_next;
                zero   <= (work_next == '0);
                state  <= ST_HOLD;
            end
        end else if ((state == ST_HOLD) && out_ready) begin
            state <= ST_IDLE;
        end
    end

`endif

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed vectors push expected results, a negedge
// monitor pops them on every output transfer. Honours ALU_BARREL_SHIFT_EN for latency.
module tb_alu_exec;
    import alu_pkg::*;

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctr;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];

    alu_exec #(.XLEN(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctr   (alu_ctr),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every cycle with an output transfer consumes one scoreboard entry.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check_output("sb_unexpected_output", result, 32'hxxxx_xxxx);
            end else begin
                logic [31:0] exp_val;
                exp_val = sb.pop_front();
                check_output("sb_result", result, exp_val);
                check_output("sb_zero", {31'd0, zero}, {31'd0, exp_val == 32'd0});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, presents one request and returns #1 after the accept edge.
    task automatic apply_stimulus(input logic [3:0] code, input logic [31:0] a,
                                  input logic [31:0] b);
        int waited = 0;
        while (in_ready !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        check_output("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        alu_ctr  = code;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        alu_ctr  = 4'hx;
        op_a     = 32'hxxxx_xxxx;
        op_b     = 32'hxxxx_xxxx;
    endtask

    task automatic run_op(input string name, input logic [3:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expected,
                          input int exp_lat);
        int lat;
        int busy_cnt;
        out_ready = 1'b1;
        sb.push_back(expected);
        apply_stimulus(code, a, b);
        lat      = 1;
        busy_cnt = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
        check_output({name, "_latency"}, lat, exp_lat);
        check_output({name, "_busy_cycles"}, busy_cnt, exp_lat - 1);
        tick();
    endtask

    function automatic int shift_lat(input int s);
        return (BARREL || s == 0) ? 1 : 1 + s;
    endfunction

    initial begin
        int stale;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctr   = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        tick();
        tick();
        check_output("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("reset_result", result, 32'd0);
        check_output("reset_zero", {31'd0, zero}, 32'd1);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        resetn = 1'b1;
        tick();

        run_op("add_wrap", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1);
        run_op("sub_zero", ALU_SUB, 32'd5, 32'd5, 32'd0, 1);
        run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'd1, 1);
        run_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'd0, 1);
        run_op("undef9", 4'd9, 32'h0000_1234, 32'h0000_0055, 32'd0, 1);
        run_op("and", ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
        run_op("or", ALU_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1);
        run_op("xor", ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
        run_op("sra4", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, shift_lat(4));
        run_op("sll1", ALU_SLL, 32'h1, 32'h21, 32'h2, shift_lat(1));
        run_op("sll0", ALU_SLL, 32'h0000_ABCD, 32'h20, 32'h0000_ABCD, shift_lat(0));
        run_op("srl31", ALU_SRL, 32'h8000_0000, 32'd31, 32'h1, shift_lat(31));

        // Back-pressure, then drain and accept in the same cycle.
        out_ready = 1'b0;
        sb.push_back(32'd7);
        apply_stimulus(ALU_ADD, 32'd3, 32'd4);
        for (int i = 0; i < 3; i++) begin
            check_output("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check_output("bp_result", result, 32'd7);
            check_output("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        alu_ctr   = ALU_XOR;
        op_a      = 32'hF;
        op_b      = 32'h3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sb.push_back(32'hC);
        #1;
        check_output("drain_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_output("b2b_out_valid", {31'd0, out_valid}, 32'd1);
        check_output("b2b_result", result, 32'hC);
        tick();

        // Reset mid-shift: nothing is pushed, so any later output is flagged by the monitor.
        out_ready = 1'b1;
        apply_stimulus(ALU_SRL, 32'hFFFF_FFFF, 32'd20);
        tick();
        tick();
        resetn = 1'b0;
        tick();
        check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("rst_result", result, 32'd0);
        check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_output("rst_zero", {31'd0, zero}, 32'd1);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        resetn = 1'b1;
        stale  = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid !== 1'b0) stale++;
            tick();
        end
        check_output("no_stale_result", stale, 32'd0);

        run_op("post_rst_add", ALU_ADD, 32'd1, 32'd2, 32'd3, 1);
        check_output("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Registered execute unit that consumes the 4-bit `ALU_ctr` code produced by the ALU decoder, together with two operands, and returns a result through a valid/ready handshake. Logic and arithmetic operations complete in one cycle. Shifts run serially, one bit per cycle, unless the barrel-shifter option is compiled in. The block sits in the execute stage between operand fetch and writeback and back-pressures the pipeline while it is busy.

## Interface
- `XLEN`, default 32: operand and result width. Supported values are 32 only; shift amount is `op_b[4:0]`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `resetn`, input, 1: reset, synchronous and active-low.
- `in_valid`, input, 1: operation request valid.
- `in_ready`, output, 1: unit can accept a request this cycle.
- `alu_ctr`, input, 4: operation code. ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLT=7, SRA=14, SLTU=15.
- `op_a`, input, XLEN: operand A; the shift source for shift operations.
- `op_b`, input, XLEN: operand B; `op_b[4:0]` is the shift amount.
- `out_valid`, output, 1: result register holds an undelivered result.
- `out_ready`, input, 1: consumer accepts the result.
- `result`, output, XLEN: operation result.
- `zero`, output, 1: high when `result == 0`.
- `busy`, output, 1: a serial shift is in progress.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - SHIFT: serial shift in progress.
  - HOLD: result waiting for the consumer.
- Transfers:
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
  - `in_ready = (state==IDLE) || (state==HOLD && out_ready)`. A new request can be accepted in the same cycle the previous result drains.
- Capture of a non-shift operation, or a shift with amount 0: compute combinationally, register into `result`, go to HOLD.
- Capture of a shift with amount s>0: load the working register with `op_a`, the counter with s, and latch the code. Go to SHIFT.
- SHIFT state, each cycle:
  - Shift the working register by 1: SLL left with zero fill; SRL right with zero fill; SRA right replicating the MSB.
  - Decrement the counter. When the counter reaches 1, write the final value to `result` and go to HOLD.
- HOLD state:
  - On `out_ready` without a new request: go to IDLE.
  - On `out_ready` with a new request: go directly to that request's next state.
- Arithmetic:
  - ADD and SUB wrap modulo 2^XLEN.
  - SLT is a signed comparison; SLTU is unsigned. Both produce 0 or 1 zero-extended.
  - Undefined codes (8–13) produce `result = 0` with normal latency.
- `result` and `zero` are stable while `out_valid` is high. They change only on a new capture or on reset.
- The `alu_ctr` and operand inputs are ignored unless an input transfer occurs.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `result`=0, `zero`=1, `busy`=0, state=IDLE, counter=0.
- Latency:
  - Request accepted at cycle N (non-shift, or shift with s=0): `out_valid` high at N+1.
  - Shift with amount s>0, without the macro: `out_valid` high at N+1+s, and `busy` is high from N+1 through N+s.
- Back-pressure: `out_valid` holds indefinitely while `out_ready` is low. No result is ever dropped or overwritten.
- Reset asserted mid-shift or in HOLD: on the next edge, abort, discard the result and return to reset values.
- `out_ready` asserted while `out_valid` is low has no effect.

## Configuration
- `ALU_BARREL_SHIFT_EN` defined: shifts are computed combinationally in one cycle. Latency is always N+1, the SHIFT state and counter are not built, and `busy` is tied to 0.
- Not defined: the serial shifter described above, one bit per cycle.

## Structure
- Shared package `alu_pkg`:
  - Operation code constants (ADD..SLTU, 4-bit).
  - FSM state enum.
  - `XLEN` default.
  - The ALU decoder also imports these codes, so both ends share one definition.
- One sub-module, `alu_comb`: the purely combinational single-cycle operations (add/sub/logic/compare, and barrel shift when enabled).
- The top level holds the FSM, counter, serial shifter and output register.

## Test plan
- ADD `op_a`=0x7FFFFFFF, `op_b`=1, `out_ready`=1 -> `result`=0x80000000 at N+1; SUB 5−5 -> `result`=0, `zero`=1.
- SLT `op_a`=0xFFFFFFFF, `op_b`=1 -> 1; SLTU with the same operands -> 0; code 9 -> `result`=0 at N+1.
- SRA `op_a`=0x80000000, `op_b`=4, without the macro -> `busy` high 4 cycles, `out_valid` at N+5, `result`=0xF8000000. With the macro -> N+1.
- SLL `op_a`=1, `op_b`=0x21 (shift amount 1) -> `result`=2; shift amount 0 -> `result`=`op_a` at N+1.
- Back-to-back: hold `out_ready`=0 for 3 cycles -> `result` stable and `in_ready`=0. Raise `out_ready` with `in_valid` high -> drain and accept in the same cycle, next result valid the following cycle.
- Drive `resetn`=0 during a 20-bit SRL -> next edge `out_valid`=0, `result`=0, `in_ready`=1, and no stale result appears afterwards.
